data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//   Two-requester arbiter and access sequencer in front of data_ram.
//   Shares the single RAM port between M0 (CPU MEM stage load/store) and
//   M1 (DMA / debug loader). Uses a req/ack handshake, round-robin
//   arbitration, and one RAM access per grant. Read data is registered
//   and returned with ack.
// PARAMETERS
//   ADDR_W  32  RAM byte address width (matches `DataAddrBus)
//   DATA_W  32  RAM data width (matches `DataBus); sel width = DATA_W/8
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   rst_n      in   1       reset, synchronous, active-low
//   m0_req     in   1       M0 access request; held until m0_ack
//   m0_we      in   1       M0 1=write, 0=read
//   m0_addr    in   ADDR_W  M0 byte address
//   m0_sel     in   4       M0 byte enables
//   m0_wdata   in   DATA_W  M0 write data
//   m0_ack     out  1       one-cycle pulse: M0 access complete
//   m0_rdata   out  DATA_W  M0 read data, valid while m0_ack=1
//   m1_*       --   --      identical set for M1 (req/we/addr/sel/wdata/ack/rdata)
//   ram_ce     out  1       to data_ram ce
//   ram_we     out  1       to data_ram we
//   ram_addr   out  ADDR_W  to data_ram addr
//   ram_sel    out  4       to data_ram sel
//   ram_wdata  out  DATA_W  to data_ram data_i
//   ram_rdata  in   DATA_W  from data_ram data_o (combinational read)
// BEHAVIOUR
//   - FSM: IDLE -> ACCESS -> DONE -> IDLE. Register gnt (0=M0, 1=M1), ptr (RR pointer).
//   - IDLE: no req -> stay. Any req -> ACCESS, gnt = winner.
//     Both req: winner = ptr. One req: that master.
//   - ACCESS (1 cycle): ram_ce=1. ram_we/addr/sel/wdata are muxed combinationally
//     from the granted master's inputs. A write commits at the closing edge.
//     A read captures ram_rdata into rdata_q at the closing edge. ptr <= ~gnt.
//   - DONE (1 cycle): gnt's ack=1 and its rdata=rdata_q. Next state is IDLE.
//     Requester drops or re-arms req at the edge closing DONE.
//   - Latency: req seen in cycle N -> RAM access in N+1 -> ack in N+2.
//     Minimum 3 cycles per access per master.
//   - Outside ACCESS: ram_ce=0, ram_we=0, ram_addr/sel/wdata=0.
//   - Unacked mX_rdata = 0. Write acks return rdata = 0.
//   - Payload must be stable from req rise to ack; arbiter samples only in ACCESS.
//   - A req deasserted before ack is a protocol violation. No recovery is defined.
//     The bench must flag it.
//   - Simultaneous new reqs in IDLE: resolved by ptr. Loser waits at most 1 grant (RR).
//   - Same-address write then read from the other master: strict order of grants.
//     The read returns the written data.
//   - sel=4'b0000 write: still sequenced and acked; RAM contents unchanged.
// Reset
//   - rst_n=0 at a posedge: state=IDLE, gnt=0, ptr=0, rdata_q=0, acks=0.
//   - ram_ce is gated with rst_n. While rst_n=0, no RAM write occurs even in ACCESS.
//     An aborted in-flight access is never acked.
// CONFIGURATION
//   DATA_RAM_ARB_M0_PRIO_EN defined: fixed priority.
//     - M0 always wins a simultaneous request. ptr is unused and held at 0.
//     - M1 can starve; intended for CPU-latency-critical builds.
//   Undefined (default): round-robin as above.
// TESTING
//   1. Reset, then M0 write addr=0x10 sel=4'hF wdata=0xDEADBEEF -> ram_ce=1,we=1 in cycle 1;
//      m0_ack in cycle 2, m0_rdata=0.
//   2. M1 read addr=0x10 after test 1 -> m1_ack cycle 2 with m1_rdata=0xDEADBEEF;
//      m0_ack stays 0.
//   3. M0 and M1 both req continuously from reset (RR) -> grants alternate M0,M1,M0,M1;
//      ack every 3 cycles. With DATA_RAM_ARB_M0_PRIO_EN: M1 never acked while M0 req held.
//   4. M0 write sel=4'b0010 data=0x0000AB00 to 0x20 (pre-filled 0x11223344);
//      then read -> 0x1122AB44.
//   5. rst_n=0 during ACCESS of M1 write 0x30=0x55AA55AA -> no ack.
//      A later read of 0x30 returns the prior contents; FSM is IDLE after reset.
//   6. Back-to-back: M0 re-arms req in cycle after ack; M1 idle -> acks at cycles 2,5,8
//      with ram_ce only in cycles 1,4,7.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter
//   Shares the single data_ram port between two requesters:
//     M0 - CPU MEM stage load/store
//     M1 - DMA / debug loader
//   Each grant runs IDLE -> ACCESS -> DONE. The RAM is touched only in the
//   ACCESS cycle. Read data is registered and returned with a one-cycle ack
//   in DONE.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   mX_req            access request, held until mX_ack
//   mX_we             1=write, 0=read
//   mX_addr           byte address
//   mX_sel            byte enables
//   mX_wdata          write data
//   mX_ack            one-cycle completion pulse
//   mX_rdata          read data, valid only while mX_ack=1 (0 otherwise)
//   ram_ce/we/addr/sel/wdata   to data_ram (all 0 outside ACCESS)
//   ram_rdata         from data_ram (combinational read)
//
// Configuration
//   DATA_RAM_ARB_M0_PRIO_EN  defined: M0 always wins a tie (M1 may starve),
//                            ptr held at 0.
//                            undefined: round-robin on ties.
// ---------------------------------------------------------------------------
module data_ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_sel,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_sel,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_sel,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;      // 0=M0, 1=M1
    logic              ptr_q, ptr_d;      // tie-break winner
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Granted master's payload, selected combinationally
    logic                gm_we;
    logic [ADDR_W-1:0]   gm_addr;
    logic [DATA_W/8-1:0] gm_sel;
    logic [DATA_W-1:0]   gm_wdata;

    // rst_n gating keeps a RAM write and a stale ack from escaping while the
    // synchronous reset is pending on an in-flight access.
    logic in_access, in_done;

    always_comb begin
        gm_we     = gnt_q ? m1_we    : m0_we;
        gm_addr   = gnt_q ? m1_addr  : m0_addr;
        gm_sel    = gnt_q ? m1_sel   : m0_sel;
        gm_wdata  = gnt_q ? m1_wdata : m0_wdata;
        in_access = (state_q == ST_ACCESS) && rst_n;
        in_done   = (state_q == ST_DONE) && rst_n;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ST_ACCESS;
                    if (m0_req && m1_req) begin
`ifdef DATA_RAM_ARB_M0_PRIO_EN
                        gnt_d = 1'b0;
`else
                        gnt_d = ptr_q;
`endif
                    end else begin
                        gnt_d = m1_req;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                // Writes return 0 with their ack.
                rdata_d = gm_we ? '0 : ram_rdata;
`ifdef DATA_RAM_ARB_M0_PRIO_EN
                ptr_d   = 1'b0;
`else
                ptr_d   = ~gnt_q;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        ram_ce    = in_access;
        ram_we    = in_access && gm_we;
        ram_addr  = in_access ? gm_addr  : '0;
        ram_sel   = in_access ? gm_sel   : '0;
        ram_wdata = in_access ? gm_wdata : '0;

        m0_ack    = in_done && !gnt_q;
        m1_ack    = in_done &&  gnt_q;
        m0_rdata  = m0_ack ? rdata_q : '0;
        m1_rdata  = m1_ack ? rdata_q : '0;
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;

    logic        clk, rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    int errors = 0;
    int checks = 0;

    data_ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_ram: combinational read, byte-masked write on posedge.
    logic [31:0] mem [0:255];
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // Protocol monitor: a req that falls before its ack is flagged.
    bit p0, p1;
    always @(posedge clk) begin
        if (!rst_n) begin
            p0 = 1'b0;
            p1 = 1'b0;
        end else begin
            if (p0) begin
                checks++;
                if (!m0_req) begin errors++; $display("FAIL m0_req_dropped_before_ack got=0 exp=1"); end
            end
            if (p1) begin
                checks++;
                if (!m1_req) begin errors++; $display("FAIL m1_req_dropped_before_ack got=0 exp=1"); end
            end
            if (m0_ack) p0 = 1'b0; else if (m0_req) p0 = 1'b1;
            if (m1_ack) p1 = 1'b0; else if (m1_req) p1 = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drop(input bit m);
        if (!m) begin m0_req = 0; m0_we = 0; m0_addr = 0; m0_sel = 0; m0_wdata = 0; end
        else    begin m1_req = 0; m1_we = 0; m1_addr = 0; m1_sel = 0; m1_wdata = 0; end
    endtask

    task automatic arm(input bit m, input bit we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        if (!m) begin m0_req = 1; m0_we = we; m0_addr = a; m0_sel = s; m0_wdata = d; end
        else    begin m1_req = 1; m1_we = we; m1_addr = a; m1_sel = s; m1_wdata = d; end
    endtask

    // Drives one transaction; reports the cycle of ack (-1 on timeout) and rdata.
    task automatic run_txn(input bit m, input bit we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           output int ack_cyc, output logic [31:0] rd);
        ack_cyc = -1;
        rd = 'x;
        arm(m, we, a, s, d);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if ((m ? m1_ack : m0_ack) === 1'b1) begin
                ack_cyc = k;
                rd = m ? m1_rdata : m0_rdata;
                cyc();
                break;
            end
        end
        drop(m);
    endtask

    task automatic test_reset();
        rst_n = 0;
        cyc(); cyc();
        checks++; if (ram_ce !== 1'b0) begin errors++; $display("FAIL reset_ram_ce got=%b exp=0", ram_ce); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got=%b exp=00", {m0_ack, m1_ack}); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL reset_m0_rdata got=%h exp=0", m0_rdata); end
        checks++; if ({ram_addr, ram_wdata} !== 64'h0) begin errors++; $display("FAIL reset_ram_bus got=%h exp=0", {ram_addr, ram_wdata}); end
        rst_n = 1;
        cyc();
    endtask

    task automatic test_write();
        arm(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        #1;
        checks++; if (ram_ce !== 1'b0) begin errors++; $display("FAIL wr_c0_ce got=%b exp=0", ram_ce); end
        cyc();
        checks++; if ({ram_ce, ram_we} !== 2'b11) begin errors++; $display("FAIL wr_c1_ce_we got=%b exp=11", {ram_ce, ram_we}); end
        checks++; if ({ram_addr, ram_sel, ram_wdata} !== {32'h10, 4'hF, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_c1_bus got=%h exp=%h", {ram_addr, ram_sel, ram_wdata}, {32'h10, 4'hF, 32'hDEADBEEF}); end
        cyc();
        checks++; if ({m0_ack, m1_ack, ram_ce} !== 3'b100) begin errors++; $display("FAIL wr_c2_ack got=%b exp=100", {m0_ack, m1_ack, ram_ce}); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL wr_c2_rdata got=%h exp=0", m0_rdata); end
        cyc();
        drop(0);
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[4]); end
    endtask

    task automatic test_read();
        arm(1, 0, 32'h10, 4'hF, 32'h0);
        cyc();
        checks++; if ({ram_ce, ram_we, ram_addr} !== {2'b10, 32'h10}) begin
            errors++; $display("FAIL rd_c1_bus got=%h exp=%h", {ram_ce, ram_we, ram_addr}, {2'b10, 32'h10}); end
        cyc();
        checks++; if ({m1_ack, m0_ack} !== 2'b10) begin errors++; $display("FAIL rd_c2_ack got=%b exp=10", {m1_ack, m0_ack}); end
        checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c2_rdata got=%h exp=deadbeef", m1_rdata); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rd_c2_m0_rdata got=%h exp=0", m0_rdata); end
        cyc();
        drop(1);
        #1;
        checks++; if ({m1_ack, m1_rdata} !== 33'h0) begin errors++; $display("FAIL rd_after_ack got=%h exp=0", {m1_ack, m1_rdata}); end
    endtask

    task automatic test_round_robin();
        int n0, n1;
        bit exp_m;
        n0 = 0; n1 = 0;
        rst_n = 0;
        cyc();
        arm(0, 0, 32'h10, 4'hF, 32'h0);
        arm(1, 0, 32'h30, 4'hF, 32'h0);
        rst_n = 1;
        for (int k = 0; k < 12; k++) begin
            #1;
`ifdef DATA_RAM_ARB_M0_PRIO_EN
            exp_m = 1'b0;
`else
            exp_m = ((k / 3) % 2) == 1;
`endif
            checks++; if (m0_ack !== (k % 3 == 2 && !exp_m)) begin
                errors++; $display("FAIL rr_m0_ack cyc=%0d got=%b exp=%b", k, m0_ack, (k % 3 == 2 && !exp_m)); end
            checks++; if (m1_ack !== (k % 3 == 2 && exp_m)) begin
                errors++; $display("FAIL rr_m1_ack cyc=%0d got=%b exp=%b", k, m1_ack, (k % 3 == 2 && exp_m)); end
            if (m0_ack === 1'b1) begin
                n0++;
                checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_m0_rdata got=%h exp=deadbeef", m0_rdata); end
            end
            if (m1_ack === 1'b1) begin
                n1++;
                checks++; if (m1_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rr_m1_rdata got=%h exp=cafef00d", m1_rdata); end
            end
            cyc();
        end
`ifdef DATA_RAM_ARB_M0_PRIO_EN
        checks++; if ({n0, n1} !== {32'd4, 32'd0}) begin errors++; $display("FAIL prio_ack_counts got=%0d,%0d exp=4,0", n0, n1); end
`else
        checks++; if ({n0, n1} !== {32'd2, 32'd2}) begin errors++; $display("FAIL rr_ack_counts got=%0d,%0d exp=2,2", n0, n1); end
`endif
        // Both requesters still armed; end the scenario through reset.
        rst_n = 0;
        drop(0); drop(1);
        cyc();
        rst_n = 1;
        cyc();
    endtask

    task automatic test_byte_sel();
        int ac;
        logic [31:0] rd;
        run_txn(0, 1, 32'h20, 4'b0010, 32'h0000AB00, ac, rd);
        checks++; if (ac !== 2 || rd !== 32'h0) begin errors++; $display("FAIL bsel_wr got=%0d/%h exp=2/0", ac, rd); end
        run_txn(0, 0, 32'h20, 4'hF, 32'h0, ac, rd);
        checks++; if (ac !== 2 || rd !== 32'h1122AB44) begin errors++; $display("FAIL bsel_rd got=%0d/%h exp=2/1122ab44", ac, rd); end
        run_txn(1, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, ac, rd);
        checks++; if (ac !== 2) begin errors++; $display("FAIL sel0_wr_ack got=%0d exp=2", ac); end
        run_txn(1, 0, 32'h20, 4'hF, 32'h0, ac, rd);
        checks++; if (rd !== 32'h1122AB44) begin errors++; $display("FAIL sel0_rd got=%h exp=1122ab44", rd); end
    endtask

    task automatic test_reset_abort();
        int ac;
        logic [31:0] rd;
        arm(1, 1, 32'h30, 4'hF, 32'h55AA55AA);
        cyc();
        checks++; if (ram_ce !== 1'b1) begin errors++; $display("FAIL abort_access_ce got=%b exp=1", ram_ce); end
        rst_n = 0;
        #1;
        checks++; if ({ram_ce, ram_we} !== 2'b00) begin errors++; $display("FAIL abort_ce_gated got=%b exp=00", {ram_ce, ram_we}); end
        cyc();
        checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack0 got=%b exp=0", m1_ack); end
        rst_n = 1;
        drop(1);
        cyc();
        checks++; if ({m1_ack, ram_ce} !== 2'b00) begin errors++; $display("FAIL abort_no_ack1 got=%b exp=00", {m1_ack, ram_ce}); end
        checks++; if (mem[12] !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_mem got=%h exp=cafef00d", mem[12]); end
        run_txn(0, 0, 32'h30, 4'hF, 32'h0, ac, rd);
        checks++; if (ac !== 2 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_reread got=%0d/%h exp=2/cafef00d", ac, rd); end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        arm(0, 0, 32'h10, 4'hF, 32'h0);
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++; if (ram_ce !== (k % 3 == 1)) begin errors++; $display("FAIL b2b_ce cyc=%0d got=%b exp=%b", k, ram_ce, (k % 3 == 1)); end
            checks++; if (m0_ack !== (k % 3 == 2)) begin errors++; $display("FAIL b2b_ack cyc=%0d got=%b exp=%b", k, m0_ack, (k % 3 == 2)); end
            if (m0_ack === 1'b1) n++;
            cyc();
        end
        drop(0);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_ack_count got=%0d exp=3", n); end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8]  <= 32'h11223344;
        mem[12] <= 32'hCAFEF00D;
        rst_n = 0;
        drop(0);
        drop(1);
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_byte_sel();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
